// File: rtl/serialcmd_pkg.sv
// Shared definitions for the serial command path: field widths, port limit
// and the bus-ownership state encoding.
package serialcmd_pkg;

  localparam int SEQ_W     = 6;
  localparam int ADR_W     = 16;
  localparam int DAT_W     = 8;
  localparam int MAX_PORTS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

endpackage

// File: rtl/serialportmux_arb.sv
// Lowest-index priority encoder used to pick the new bus owner when the mux
// is idle. Purely combinational.
module serialportmux_arb
  import serialcmd_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  output logic [2:0]           idx,
  output logic                 valid
);

  // Scan from the top so the lowest requesting index is written last and wins.
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (req[p]) begin
        idx = 3'(p);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/serialportmux.sv
// Serial port multiplexer: several command ports share one command decoder
// and one tx byte stream. The first port to strobe owns the bus until it has
// been idle for IDLE_TIMEOUT cycles with no tx byte pending.
// Optional feature macro: SERIALPORTMUX_DROPCNT_EN enables the saturating
// dropped-command counter; without it drop_count is tied to zero.
module serialportmux
  import serialcmd_pkg::*;
#(
  parameter int          NUM_PORTS    = 2,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd1200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       port_stb_i,
  input  logic [SEQ_W*NUM_PORTS-1:0] port_seq_i,
  input  logic [NUM_PORTS-1:0]       port_we_i,
  input  logic [ADR_W*NUM_PORTS-1:0] port_adr_i,
  input  logic [DAT_W*NUM_PORTS-1:0] port_dat_i,
  output logic [DAT_W*NUM_PORTS-1:0] port_tx_data,
  output logic [NUM_PORTS-1:0]       port_tx_avail,
  input  logic [NUM_PORTS-1:0]       port_tx_pull,
  output logic                       stb_o,
  output logic [SEQ_W-1:0]           seq_o,
  output logic                       we_o,
  output logic [ADR_W-1:0]           adr_o,
  output logic [DAT_W-1:0]           dat_o,
  input  logic [DAT_W-1:0]           tx_data,
  input  logic                       tx_avail,
  output logic                       tx_pull,
  output logic                       owner_valid,
  output logic [2:0]                 owner_id,
  output logic [7:0]                 drop_count
);

  state_t               state_r, state_nxt_s;
  logic [2:0]           owner_r, owner_nxt_s;
  logic [23:0]          cnt_r, cnt_nxt_s;
  logic [2:0]           arb_idx_s;
  logic                 arb_valid_s;
  logic [NUM_PORTS-1:0] owner_mask_s, win_mask_s, acc_mask_s;
  logic                 owned_s, accept_s;
  logic [SEQ_W-1:0]     seq_s,  seq_r;
  logic                 we_s,   we_r;
  logic [ADR_W-1:0]     adr_s,  adr_r;
  logic [DAT_W-1:0]     dat_s,  dat_r;
  logic                 stb_r;

  serialportmux_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req   (port_stb_i),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Gate on rst as well so the tx handshake is dead while reset is held.
  assign owned_s = (state_r == ST_OWNED) && !rst;

  // One-hot decode of the current owner and of the arbitration winner.
  always_comb begin
    owner_mask_s = '0;
    win_mask_s   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      owner_mask_s[p] = (owner_r == 3'(p));
      win_mask_s[p]   = (arb_idx_s == 3'(p)) && arb_valid_s;
    end
  end

  // Tx byte stream is routed only to the owner; data fans out to every port.
  assign port_tx_data  = {NUM_PORTS{tx_data}};
  assign port_tx_avail = (owned_s && tx_avail) ? owner_mask_s : '0;
  assign tx_pull       = owned_s && tx_avail && (|(port_tx_pull & owner_mask_s));

  // Next-state, ownership, idle counter and accepted-port selection.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    cnt_nxt_s   = cnt_r;
    acc_mask_s  = '0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = 24'd0;
        if (arb_valid_s) begin
          state_nxt_s = ST_OWNED;
          owner_nxt_s = arb_idx_s;
          acc_mask_s  = win_mask_s;
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      ST_OWNED: begin
        if ((cnt_r == IDLE_TIMEOUT) && !tx_avail) begin
          // Release edge: no strobe is accepted, even from the owner.
          state_nxt_s = ST_IDLE;
          owner_nxt_s = 3'd0;
          cnt_nxt_s   = 24'd0;
        end else if (|(port_stb_i & owner_mask_s)) begin
          acc_mask_s = owner_mask_s;
          cnt_nxt_s  = 24'd0;
        end else if (tx_pull) begin
          cnt_nxt_s = 24'd0;
        end else if (cnt_r != IDLE_TIMEOUT) begin
          cnt_nxt_s = cnt_r + 24'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        owner_nxt_s = 3'd0;
        cnt_nxt_s   = 24'd0;
      end
    endcase
  end

  assign accept_s = |(port_stb_i & acc_mask_s);

  // Select the fields of the accepted port (mask is one-hot or zero).
  always_comb begin
    seq_s = '0;
    we_s  = 1'b0;
    adr_s = '0;
    dat_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (acc_mask_s[p]) begin
        seq_s = port_seq_i[SEQ_W*p +: SEQ_W];
        we_s  = port_we_i[p];
        adr_s = port_adr_i[ADR_W*p +: ADR_W];
        dat_s = port_dat_i[DAT_W*p +: DAT_W];
      end else begin
        seq_s = seq_s;
      end
    end
  end

  // State, owner and idle counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= 3'd0;
      cnt_r   <= 24'd0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Forwarded command: strobe pulses one cycle, fields hold until next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_r <= 1'b0;
      seq_r <= '0;
      we_r  <= 1'b0;
      adr_r <= '0;
      dat_r <= '0;
    end else if (accept_s) begin
      stb_r <= 1'b1;
      seq_r <= seq_s;
      we_r  <= we_s;
      adr_r <= adr_s;
      dat_r <= dat_s;
    end else begin
      stb_r <= 1'b0;
    end
  end

  assign stb_o       = stb_r;
  assign seq_o       = seq_r;
  assign we_o        = we_r;
  assign adr_o       = adr_r;
  assign dat_o       = dat_r;
  assign owner_valid = owned_s;
  assign owner_id    = owner_r;

`ifdef SERIALPORTMUX_DROPCNT_EN
  logic       drop_s;
  logic [7:0] drop_cnt_r;

  // Any strobe that was not the accepted one this cycle is a drop.
  assign drop_s = |(port_stb_i & ~acc_mask_s);

  // Saturating count of cycles with at least one discarded strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_serialportmux.sv
// Directed bench for serialportmux (2 ports, IDLE_TIMEOUT=10). Works with or
// without SERIALPORTMUX_DROPCNT_EN; drop expectations follow the macro.
module tb_serialportmux;

  localparam int NP = 2;
`ifdef SERIALPORTMUX_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] stb, we, tpull;
  logic [11:0]   seq;
  logic [31:0]   adr;
  logic [15:0]   dat;
  logic [15:0]   ptx_data;
  logic [NP-1:0] ptx_avail;
  logic          stb_o, we_o, tx_avail, tx_pull, owner_valid;
  logic [5:0]    seq_o;
  logic [15:0]   adr_o;
  logic [7:0]    dat_o, tx_data, drop_count;
  logic [2:0]    owner_id;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int pulls = 0;

  serialportmux #(.NUM_PORTS(NP), .IDLE_TIMEOUT(24'd10)) dut (
    .clk(clk), .rst(rst),
    .port_stb_i(stb), .port_seq_i(seq), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dat),
    .port_tx_data(ptx_data), .port_tx_avail(ptx_avail), .port_tx_pull(tpull),
    .stb_o(stb_o), .seq_o(seq_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .tx_data(tx_data), .tx_avail(tx_avail), .tx_pull(tx_pull),
    .owner_valid(owner_valid), .owner_id(owner_id), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int p, input logic [5:0] s, input logic w,
                     input logic [15:0] a, input logic [7:0] d);
    stb[p]         = 1'b1;
    seq[6*p +: 6]  = s;
    we[p]          = w;
    adr[16*p +: 16] = a;
    dat[8*p +: 8]  = d;
  endtask

  task automatic bump_drop();
    if (DROP_EN && exp_drop < 255) exp_drop++;
  endtask

  initial begin
    rst = 1'b1; stb = '0; we = '0; tpull = '0; seq = '0; adr = '0; dat = '0;
    tx_data = 8'h00; tx_avail = 1'b0;
    tick(); tick();
    chk("rst_owner_valid", owner_valid, 0);
    chk("rst_owner_id", owner_id, 0);
    chk("rst_stb_o", stb_o, 0);
    chk("rst_adr_o", adr_o, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    tick();

    // Port 1 takes the idle bus.
    cmd(1, 6'd5, 1'b1, 16'h1234, 8'h5A);
    tick(); stb = '0;
    chk("fwd_stb", stb_o, 1);
    chk("fwd_adr", adr_o, 32'h1234);
    chk("fwd_dat", dat_o, 32'h5A);
    chk("fwd_we", we_o, 1);
    chk("fwd_seq", seq_o, 5);
    chk("fwd_owner", owner_id, 1);
    chk("fwd_valid", owner_valid, 1);
    tick();
    chk("fwd_stb_pulse", stb_o, 0);
    chk("fwd_adr_hold", adr_o, 32'h1234);

    // Non-owner strobe is discarded.
    cmd(0, 6'd1, 1'b0, 16'hBEEF, 8'h11);
    tick(); stb = '0; bump_drop();
    chk("nonowner_stb", stb_o, 0);
    chk("nonowner_owner", owner_id, 1);
    chk("nonowner_adr", adr_o, 32'h1234);
    chk("nonowner_drop", drop_count, exp_drop);

    // Owner strobe, then idle timeout: owner held 10 cycles, gone on the 11th.
    cmd(1, 6'd6, 1'b0, 16'h4321, 8'h77);
    tick(); stb = '0;
    chk("owner_stb", stb_o, 1);
    chk("owner_adr", adr_o, 32'h4321);
    for (int i = 0; i < 10; i++) tick();
    chk("timeout_hold", owner_valid, 1);
    tick();
    chk("timeout_release", owner_valid, 0);

    // Simultaneous strobes: lowest index wins.
    cmd(0, 6'd2, 1'b1, 16'hAAAA, 8'h01);
    cmd(1, 6'd3, 1'b0, 16'hBBBB, 8'h02);
    tick(); stb = '0; bump_drop();
    chk("both_owner", owner_id, 0);
    chk("both_adr", adr_o, 32'hAAAA);
    chk("both_dat", dat_o, 32'h01);
    chk("both_drop", drop_count, exp_drop);

    // Tx routing to owner 0.
    tx_avail = 1'b1; tx_data = 8'hA5; tpull = 2'b10; #1;
    chk("tx_avail_route", ptx_avail, 2'b01);
    chk("tx_data_fanout", ptx_data, 16'hA5A5);
    chk("tx_pull_nonowner", tx_pull, 0);
    pulls = 0;
    tpull = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (tx_pull === 1'b1) pulls++;
      if (ptx_avail[1] !== 1'b0) pulls += 100;
      tick();
    end
    tpull = 2'b00; #1;
    chk("tx_pull_cycles", pulls, 3);
    chk("tx_pull_off", tx_pull, 0);

    // tx_avail held defers release until it drops.
    for (int i = 0; i < 15; i++) tick();
    chk("defer_hold", owner_valid, 1);
    tx_avail = 1'b0;
    tick();
    chk("defer_release", owner_valid, 0);
    tx_avail = 1'b1; tpull = 2'b01; #1;
    chk("idle_tx_pull", tx_pull, 0);
    chk("idle_tx_avail", ptx_avail, 2'b00);
    tx_avail = 1'b0; tpull = 2'b00;

    // Strobe on the release edge is lost.
    cmd(1, 6'd9, 1'b0, 16'h5555, 8'h09);
    tick(); stb = '0;
    for (int i = 0; i < 10; i++) tick();
    chk("rel_pre", owner_valid, 1);
    cmd(1, 6'd10, 1'b1, 16'h6666, 8'h0A);
    tick(); stb = '0; bump_drop();
    chk("rel_valid", owner_valid, 0);
    chk("rel_stb", stb_o, 0);
    chk("rel_adr", adr_o, 32'h5555);
    chk("rel_drop", drop_count, exp_drop);
    tick();
    chk("rel_after", owner_valid, 0);

    // Reset mid-message.
    cmd(1, 6'd11, 1'b0, 16'h7777, 8'h0B);
    tick(); stb = '0;
    tx_avail = 1'b1; tpull = 2'b10; #1;
    chk("pre_rst_pull", tx_pull, 1);
    rst = 1'b1; #1;
    chk("rst_mid_valid", owner_valid, 0);
    chk("rst_mid_pull", tx_pull, 0);
    chk("rst_mid_avail", ptx_avail, 2'b00);
    chk("rst_mid_drop", drop_count, 0);
    chk("rst_mid_adr", adr_o, 0);
    exp_drop = 0;
    tick();
    rst = 1'b0; tx_avail = 1'b0; tpull = 2'b00;
    cmd(0, 6'd12, 1'b1, 16'h0C0C, 8'h0C);
    tick(); stb = '0;
    chk("post_rst_owner", owner_id, 0);
    chk("post_rst_valid", owner_valid, 1);
    chk("post_rst_adr", adr_o, 32'h0C0C);

    // 300 dropped strobes while owner 0 keeps the bus busy.
    for (int i = 0; i < 300; i++) begin
      cmd(0, 6'd1, 1'b0, 16'h0100, 8'h10);
      cmd(1, 6'd2, 1'b0, 16'h0200, 8'h20);
      tick();
      bump_drop();
    end
    stb = '0;
    chk("sat_drop", drop_count, exp_drop);
    chk("sat_owner", owner_id, 0);
    chk("sat_adr", adr_o, 32'h0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
